// File: rtl/tod_event_scheduler.sv
// Time-of-day event sequencer: latch event plus 32 seconds bits, sharing the stream with user events.
// Build option TOD_AUTO_INCREMENT_EN: an internal seconds counter supplies the transmitted value.
module tod_event_scheduler #(
    parameter int unsigned EVENT_GAP = 4,
    parameter logic [7:0]  NULL_CODE = 8'h00
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Pps,
    input  logic [31:0] NextSeconds,
    input  logic        SecondsLoad,
    input  logic [7:0]  UserEvent,
    input  logic        UserValid,
    output logic        UserReady,
    output logic [7:0]  EventStream,
    output logic        Busy,
    output logic        Overrun,
    output logic        Illegal
);

    // state | meaning
    // IDLE  | no sequence running; every slot is open to user events
    // LATCH | 0x7D is on EventStream this cycle
    // GAP   | spacing slot between TOD events; carries a user event or NULL_CODE
    // SHIFT | one seconds bit (0x70/0x71) is on EventStream this cycle
    typedef enum logic [1:0] {IDLE, LATCH, GAP, SHIFT} state_t;

    localparam logic [7:0] CODE_LATCH = 8'h7D;
    localparam logic [7:0] CODE_ZERO  = 8'h70;
    localparam logic [7:0] CODE_ONE   = 8'h71;
    localparam bit         HAS_GAP    = (EVENT_GAP > 0);
    localparam logic [3:0] GAP_RELOAD = HAS_GAP ? 4'(EVENT_GAP - 1) : 4'd0;

    state_t      state;
    logic [31:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic [3:0]  gap_cnt;
    logic [7:0]  event_q;
    logic        overrun_q;
    logic        illegal_q;

    logic        next_is_gap;
    logic        user_fire;
    logic        user_illegal;
    logic [7:0]  user_slot;
    logic [7:0]  tod_code;
    logic [31:0] capture_value;

`ifdef TOD_AUTO_INCREMENT_EN
    logic [31:0] seconds_cnt;

    always_ff @(posedge Clock) begin
        if (Reset)
            seconds_cnt <= 32'd0;
        else if (SecondsLoad)
            seconds_cnt <= NextSeconds;
        else if (Pps)
            seconds_cnt <= seconds_cnt + 32'd1;
    end

    assign capture_value = SecondsLoad ? NextSeconds : seconds_cnt + 32'd1;
`else
    logic unused_seconds_load;
    assign unused_seconds_load = SecondsLoad;
    assign capture_value       = NextSeconds;
`endif

    // A user event accepted now lands in the next slot, so readiness looks one slot ahead.
    always_comb begin
        next_is_gap = 1'b0;
        if (HAS_GAP) begin
            case (state)
                LATCH:   next_is_gap = 1'b1;
                GAP:     next_is_gap = (gap_cnt != 4'd0);
                SHIFT:   next_is_gap = (bit_cnt != 5'd0);
                default: next_is_gap = 1'b0;
            endcase
        end
    end

    assign UserReady    = !Reset && !Pps && ((state == IDLE) || next_is_gap);
    assign user_fire    = UserValid && UserReady;
    assign user_illegal = (UserEvent == CODE_ZERO) || (UserEvent == CODE_ONE) ||
                          (UserEvent == CODE_LATCH);
    assign user_slot    = (user_fire && !user_illegal) ? UserEvent : NULL_CODE;
    assign tod_code     = shift_reg[31] ? CODE_ONE : CODE_ZERO;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            shift_reg <= 32'd0;
            bit_cnt   <= 5'd0;
            gap_cnt   <= 4'd0;
            event_q   <= NULL_CODE;
            overrun_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (user_fire && user_illegal)
                illegal_q <= 1'b1;
            if (Pps) begin
                if (state != IDLE)
                    overrun_q <= 1'b1;
                shift_reg <= capture_value;
                bit_cnt   <= 5'd31;
                state     <= LATCH;
                event_q   <= CODE_LATCH;
            end else begin
                event_q <= user_slot;
                case (state)
                    LATCH: begin
                        if (HAS_GAP) begin
                            state   <= GAP;
                            gap_cnt <= GAP_RELOAD;
                        end else begin
                            state     <= SHIFT;
                            event_q   <= tod_code;
                            shift_reg <= {shift_reg[30:0], 1'b0};
                        end
                    end
                    GAP: begin
                        if (gap_cnt != 4'd0) begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end else begin
                            state     <= SHIFT;
                            event_q   <= tod_code;
                            shift_reg <= {shift_reg[30:0], 1'b0};
                        end
                    end
                    SHIFT: begin
                        if (bit_cnt == 5'd0) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                            if (HAS_GAP) begin
                                state   <= GAP;
                                gap_cnt <= GAP_RELOAD;
                            end else begin
                                event_q   <= tod_code;
                                shift_reg <= {shift_reg[30:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign EventStream = event_q;
    assign Busy        = (state != IDLE);
    assign Overrun     = overrun_q;
    assign Illegal     = illegal_q;

endmodule

// File: tb/tb_tod_event_scheduler.sv
// Bench for tod_event_scheduler: slot-arithmetic reference model, directed scenarios and random traffic.
// Define TOD_AUTO_INCREMENT_EN to also cover the internal seconds counter.
module tb_tod_event_scheduler;
    localparam int G    = 4;
    localparam int LAST = 2 + G + 31 * (G + 1);

    logic        Clock = 1'b0;
    logic        Reset, Pps, SecondsLoad, UserValid;
    logic [31:0] NextSeconds;
    logic [7:0]  UserEvent;
    logic        UserReady, Busy, Overrun, Illegal;
    logic [7:0]  EventStream;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: sequence start cycle and value, sticky flags
    longint      cyc = 0;
    bit          m_active = 0;
    longint      m_start = 0;
    logic [31:0] m_val = 0;
    bit          m_overrun = 0;
    bit          m_illegal = 0;
    logic [31:0] m_secs = 0;
    logic [7:0]  exp_es = 8'h00;
    bit          exp_ready = 0;
    logic        obs_ready;

    always #5 Clock = ~Clock;

    tod_event_scheduler #(.EVENT_GAP(G), .NULL_CODE(8'h00)) dut (
        .Clock(Clock), .Reset(Reset), .Pps(Pps), .NextSeconds(NextSeconds),
        .SecondsLoad(SecondsLoad), .UserEvent(UserEvent), .UserValid(UserValid),
        .UserReady(UserReady), .EventStream(EventStream), .Busy(Busy),
        .Overrun(Overrun), .Illegal(Illegal)
    );

    function automatic bit busy_at(longint c);
        return m_active && (c - m_start) >= 1 && (c - m_start) <= LAST;
    endfunction

    // Index n of the seconds bit emitted in cycle c (0 = bit31), or -1
    function automatic int bit_index(longint c);
        longint k;
        if (!m_active) return -1;
        k = c - m_start - 2 - G;
        if (k < 0 || (k % (G + 1)) != 0 || (k / (G + 1)) > 31) return -1;
        return int'(k / (G + 1));
    endfunction

    function automatic bit gap_at(longint c);
        return busy_at(c) && (c - m_start) != 1 && bit_index(c) < 0;
    endfunction

    // Drive one cycle of inputs, sample UserReady, advance the model across the edge
    task automatic step(input bit rst, input bit pps, input bit valid, input logic [7:0] ev,
                        input logic [31:0] ns, input bit load);
        logic [31:0] cap;
        bit fire;
        int n;
        @(negedge Clock);
        Reset = rst; Pps = pps; UserValid = valid; UserEvent = ev;
        NextSeconds = ns; SecondsLoad = load;
        #1;
        exp_ready = !rst && !pps && (!busy_at(cyc) || gap_at(cyc + 1));
        obs_ready = UserReady;
        fire = valid && exp_ready;
        if (rst) begin
            m_active = 0; m_overrun = 0; m_illegal = 0; m_secs = 0; exp_es = 8'h00;
        end else begin
`ifdef TOD_AUTO_INCREMENT_EN
            if (load) m_secs = ns;
            else if (pps) m_secs = m_secs + 32'd1;
            cap = m_secs;
`else
            cap = ns;
`endif
            if (pps) begin
                if (busy_at(cyc)) m_overrun = 1;
                m_active = 1; m_start = cyc; m_val = cap; exp_es = 8'h7D;
            end else begin
                n = bit_index(cyc + 1);
                if (n >= 0) exp_es = m_val[31 - n] ? 8'h71 : 8'h70;
                else if (fire) begin
                    if (ev == 8'h70 || ev == 8'h71 || ev == 8'h7D) begin
                        m_illegal = 1; exp_es = 8'h00;
                    end else exp_es = ev;
                end else exp_es = 8'h00;
            end
        end
        @(posedge Clock);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 8'h00, 32'h0, 0);
        step(1, 1, 1, 8'h55, 32'h1234, 0);
        vectors++; if (EventStream !== 8'h00) begin miscompares++; $display("FAIL reset_es got %h want 00", EventStream); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", Busy); end
        vectors++; if (Overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", Overrun); end
        vectors++; if (Illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got %b want 0", Illegal); end
        vectors++; if (obs_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", obs_ready); end
        step(0, 0, 0, 8'h00, 32'h0, 0);
        vectors++; if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready got %b want 1", obs_ready); end
    endtask

    task automatic test_tod_sequence();
        logic [31:0] rx = 0;
        int nb = 0;
        longint t0 = cyc;
        longint fall = -1;
        step(0, 1, 0, 8'h00, 32'hA5A5_0001, 0);
        for (int i = 0; i < 170; i++) begin
            vectors++; if (EventStream !== exp_es) begin miscompares++; $display("FAIL seq_es cyc+%0d got %h want %h", cyc - t0, EventStream, exp_es); end
            vectors++; if (Busy !== busy_at(cyc)) begin miscompares++; $display("FAIL seq_busy cyc+%0d got %b want %b", cyc - t0, Busy, busy_at(cyc)); end
            if (EventStream == 8'h7D) begin rx = 0; nb = 0; end
            else if (EventStream == 8'h70 || EventStream == 8'h71) begin rx = {rx[30:0], EventStream[0]}; nb++; end
            if (fall < 0 && i > 0 && Busy === 1'b0) fall = cyc - t0;
            step(0, 0, 0, 8'h00, 32'h0, 0);
        end
        vectors++; if (rx !== 32'hA5A5_0001 || nb != 32) begin miscompares++; $display("FAIL seq_decode got %h/%0d bits want a5a50001/32", rx, nb); end
        vectors++; if (fall != 162) begin miscompares++; $display("FAIL seq_busy_fall got t+%0d want t+162", fall); end
    endtask

    task automatic test_user_fill();
        int n2a = 0;
        step(0, 1, 1, 8'h2A, $urandom, 0);
        for (int i = 0; i < 161; i++) begin
            vectors++; if (EventStream !== exp_es) begin miscompares++; $display("FAIL fill_es got %h want %h", EventStream, exp_es); end
            vectors++; if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL fill_ready got %b want %b", obs_ready, exp_ready); end
            if (EventStream == 8'h2A) n2a++;
            step(0, 0, 1, 8'h2A, 32'h0, 0);
        end
        vectors++; if (n2a != 32 * G) begin miscompares++; $display("FAIL fill_count got %0d want %0d", n2a, 32 * G); end
    endtask

    task automatic test_overrun();
        logic [31:0] rx = 0;
        int nb = 0;
        step(0, 1, 0, 8'h00, $urandom, 0);
        for (int i = 1; i < 50; i++) step(0, 0, 0, 8'h00, 32'h0, 0);
        step(0, 1, 0, 8'h00, 32'h0000_0003, 0);
        vectors++; if (EventStream !== 8'h7D) begin miscompares++; $display("FAIL ovr_latch got %h want 7d", EventStream); end
        vectors++; if (Overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", Overrun); end
        for (int i = 0; i < 170; i++) begin
            vectors++; if (EventStream !== exp_es) begin miscompares++; $display("FAIL ovr_es got %h want %h", EventStream, exp_es); end
            if (EventStream == 8'h7D) begin rx = 0; nb = 0; end
            else if (EventStream == 8'h70 || EventStream == 8'h71) begin rx = {rx[30:0], EventStream[0]}; nb++; end
            step(0, 0, 0, 8'h00, 32'h0, 0);
        end
        vectors++; if (rx !== 32'h0000_0003 || nb != 32) begin miscompares++; $display("FAIL ovr_decode got %h/%0d bits want 00000003/32", rx, nb); end
    endtask

    task automatic test_illegal();
        step(0, 0, 1, 8'h7D, 32'h0, 0);
        vectors++; if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL ill_ready got %b want 1", obs_ready); end
        vectors++; if (EventStream !== 8'h00) begin miscompares++; $display("FAIL ill_es got %h want 00", EventStream); end
        vectors++; if (Illegal !== 1'b1) begin miscompares++; $display("FAIL ill_flag got %b want 1", Illegal); end
        step(0, 0, 1, 8'h3C, 32'h0, 0);
        vectors++; if (EventStream !== 8'h3C) begin miscompares++; $display("FAIL legal_es got %h want 3c", EventStream); end
        vectors++; if (Illegal !== 1'b1) begin miscompares++; $display("FAIL ill_sticky got %b want 1", Illegal); end
    endtask

    task automatic test_mid_reset();
        int ntod = 0;
        step(0, 1, 0, 8'h00, $urandom, 0);
        for (int i = 1; i < 30; i++) step(0, 0, 0, 8'h00, 32'h0, 0);
        step(1, 0, 0, 8'h00, 32'h0, 0);
        vectors++; if (EventStream !== 8'h00) begin miscompares++; $display("FAIL mrst_es got %h want 00", EventStream); end
        vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL mrst_busy got %b want 0", Busy); end
        vectors++; if (Overrun !== 1'b0) begin miscompares++; $display("FAIL mrst_overrun got %b want 0", Overrun); end
        for (int i = 0; i < 170; i++) begin
            step(0, 0, 0, 8'h00, 32'h0, 0);
            if (EventStream == 8'h70 || EventStream == 8'h71) ntod++;
        end
        vectors++; if (ntod != 0) begin miscompares++; $display("FAIL mrst_tod_after got %0d events want 0", ntod); end
    endtask

`ifdef TOD_AUTO_INCREMENT_EN
    task automatic test_auto_increment();
        logic [31:0] want [3];
        logic [31:0] rx;
        int nb;
        want[0] = 32'hFFFF_FFFE; want[1] = 32'hFFFF_FFFF; want[2] = 32'h0000_0000;
        step(1, 0, 0, 8'h00, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            rx = 32'h1234_5678; nb = 0;
            step(0, 1, 0, 8'h00, (k == 0) ? 32'hFFFF_FFFE : 32'h5555_AAAA, k == 0);
            for (int i = 0; i < 165; i++) begin
                vectors++; if (EventStream !== exp_es) begin miscompares++; $display("FAIL auto_es got %h want %h", EventStream, exp_es); end
                if (EventStream == 8'h7D) begin rx = 0; nb = 0; end
                else if (EventStream == 8'h70 || EventStream == 8'h71) begin rx = {rx[30:0], EventStream[0]}; nb++; end
                step(0, 0, 0, 8'h00, 32'h0, 0);
            end
            vectors++; if (rx !== want[k] || nb != 32) begin miscompares++; $display("FAIL auto_decode%0d got %h want %h", k, rx, want[k]); end
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] ill [3];
        logic [7:0] ev;
        ill[0] = 8'h70; ill[1] = 8'h71; ill[2] = 8'h7D;
        for (int i = 0; i < 4000; i++) begin
            ev = ($urandom_range(3) == 0) ? ill[$urandom_range(2)] : 8'($urandom);
            step($urandom_range(999) == 0, $urandom_range(149) == 0, 1'($urandom_range(1)), ev,
                 $urandom, $urandom_range(15) == 0);
            vectors++; if (EventStream !== exp_es) begin miscompares++; $display("FAIL rnd_es i=%0d got %h want %h", i, EventStream, exp_es); end
            vectors++; if (Busy !== busy_at(cyc)) begin miscompares++; $display("FAIL rnd_busy i=%0d got %b want %b", i, Busy, busy_at(cyc)); end
            vectors++; if (Overrun !== m_overrun) begin miscompares++; $display("FAIL rnd_overrun i=%0d got %b want %b", i, Overrun, m_overrun); end
            vectors++; if (Illegal !== m_illegal) begin miscompares++; $display("FAIL rnd_illegal i=%0d got %b want %b", i, Illegal, m_illegal); end
            vectors++; if (obs_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready i=%0d got %b want %b", i, obs_ready, exp_ready); end
        end
    endtask

    initial begin
        Reset = 1'b1; Pps = 1'b0; SecondsLoad = 1'b0; UserValid = 1'b0;
        UserEvent = 8'h00; NextSeconds = 32'h0;
        test_reset();
        test_tod_sequence();
        test_user_fill();
        test_overrun();
        test_illegal();
        test_mid_reset();
`ifdef TOD_AUTO_INCREMENT_EN
        test_auto_increment();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
